// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one registered-output image ROM between the video
// pixel-fetch path and an auxiliary burst reader.
//
// Three-stage slot pipeline:
//   S0  arbitration; winner address goes to o_rom_row/o_rom_col, tag to r_tag_s1
//   S1  ROM samples the held address; tag moves to r_tag_s2
//   S2  i_rom_data is steered to the video or aux output named by r_tag_s2
//
// Video has absolute priority and no handshake. Aux bursts fill idle slots.
//
// Aux request handshake: i_aux_req is sampled only while the aux FSM is idle.
// The edge that samples it registers a one-cycle o_aux_ack pulse, whether or not
// the length is legal. A legal length (1..MAX_LEN) also starts the burst.
// o_aux_busy stays high until the last pixel of the burst has been returned.
// Requests made while busy are ignored and get no ack.
//
// Optional feature: define ARB_STARVE_GUARD_EN to add the starvation guard.
// If video has blocked a pending aux slot for STARVE_LIMIT cycles, the guard
// steals one slot for aux. The stolen video pixel is replaced by the previous
// one, and o_vid_stolen marks it.
module rom_port_arbiter #(
  parameter int IMG_W        = 584,
  parameter int IMG_H        = 167,
  parameter int MAX_LEN      = 64,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vid_en,
  input  logic [7:0]  i_vid_row,
  input  logic [9:0]  i_vid_col,
  output logic        o_vid_valid,
  output logic [11:0] o_vid_data,
`ifdef ARB_STARVE_GUARD_EN
  output logic        o_vid_stolen,
`endif
  input  logic        i_aux_req,
  output logic        o_aux_ack,
  input  logic [7:0]  i_aux_row,
  input  logic [9:0]  i_aux_col,
  input  logic [6:0]  i_aux_len,
  output logic        o_aux_valid,
  output logic [11:0] o_aux_data,
  output logic        o_aux_last,
  output logic        o_aux_busy,
  output logic [1:0]  o_aux_state,
  output logic [7:0]  o_rom_row,
  output logic [9:0]  o_rom_col,
  input  logic [11:0] i_rom_data
);

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_DRAIN = 2'd2
  } aux_state_t;

  typedef enum logic [1:0] {
    T_NONE     = 2'd0,
    T_VID      = 2'd1,
    T_AUX      = 2'd2,
    T_AUX_LAST = 2'd3
  } tag_t;

  localparam logic [7:0]  LP_IMG_H   = 8'(IMG_H);
  localparam logic [10:0] LP_IMG_W   = 11'(IMG_W);
  localparam logic [6:0]  LP_MAX_LEN = 7'(MAX_LEN);

  // Aux FSM and latched burst descriptor
  aux_state_t  r_state;
  aux_state_t  w_state_nxt;
  logic [7:0]  r_aux_row;
  logic [9:0]  r_aux_col;
  logic [6:0]  r_aux_len;
  logic [6:0]  r_aux_k;

  // FSM decisions for the current cycle
  logic        w_ack_nxt;
  logic        w_accept;
  logic        w_aux_slot;
  logic        w_steal;

  // Slot-pipeline tags
  tag_t        r_tag_s1;
  tag_t        r_tag_s2;
  logic        r_oor_s1;
  logic        r_oor_s2;
  logic        r_steal_s1;
  logic        r_steal_s2;

  // Address and range helpers
  logic        w_len_ok;
  logic [10:0] w_aux_col;
  logic        w_aux_at_last;
  logic        w_aux_oor;
  logic        w_vid_oor;

  assign w_len_ok      = (i_aux_len != 7'd0) && (i_aux_len <= LP_MAX_LEN);
  // 11-bit column so col+k past 1023 stays out of range and never wraps
  assign w_aux_col     = {1'b0, r_aux_col} + {4'd0, r_aux_k};
  assign w_aux_at_last = (r_aux_k == (r_aux_len - 7'd1));
  assign w_aux_oor     = (r_aux_row >= LP_IMG_H) || (w_aux_col >= LP_IMG_W);
  assign w_vid_oor     = (i_vid_row >= LP_IMG_H) || ({1'b0, i_vid_col} >= LP_IMG_W);

  assign o_aux_busy  = (r_state != A_IDLE);
  assign o_aux_state = r_state;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LP_STARVE = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] r_starve_cnt;

  // Steal a slot once video has blocked a pending aux slot for the limit
  assign w_steal = i_vid_en && (r_state == A_ISSUE) && (r_starve_cnt >= LP_STARVE);

  // Count cycles during which video blocks a pending aux slot; clear on any aux issue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if ((r_state != A_ISSUE) || w_aux_slot) begin
      r_starve_cnt <= '0;
    end else if (i_vid_en && (r_starve_cnt < LP_STARVE)) begin
      r_starve_cnt <= r_starve_cnt + SC_W'(1);
    end
  end
`else
  assign w_steal = 1'b0;
`endif

  // Aux FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= A_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Aux FSM next state, accept/ack decisions and slot issue
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_accept    = 1'b0;
    w_aux_slot  = 1'b0;
    case (r_state)
      A_IDLE: begin
        if (i_aux_req) begin
          w_ack_nxt = 1'b1;
          if (w_len_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = A_ISSUE;
          end
        end
      end
      A_ISSUE: begin
        if (!i_vid_en || w_steal) begin
          w_aux_slot = 1'b1;
          if (w_aux_at_last) begin
            w_state_nxt = A_DRAIN;
          end
        end
      end
      A_DRAIN: begin
        // The last pixel leaves S2 on this edge; the burst is complete
        if (r_tag_s2 == T_AUX_LAST) begin
          w_state_nxt = A_IDLE;
        end
      end
      default: w_state_nxt = A_IDLE;
    endcase
  end

  // Latch the burst descriptor on accept; advance the pixel index per issued slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aux_row <= 8'd0;
      r_aux_col <= 10'd0;
      r_aux_len <= 7'd0;
      r_aux_k   <= 7'd0;
    end else if (w_accept) begin
      r_aux_row <= i_aux_row;
      r_aux_col <= i_aux_col;
      r_aux_len <= i_aux_len;
      r_aux_k   <= 7'd0;
    end else if (w_aux_slot) begin
      r_aux_k   <= r_aux_k + 7'd1;
    end
  end

  // Ack pulse registered on the edge that samples the request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_aux_ack <= 1'b0;
    end else begin
      o_aux_ack <= w_ack_nxt;
    end
  end

  // S0: register the winning address and its tag; idle slots hold the address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_row  <= 8'd0;
      o_rom_col  <= 10'd0;
      r_tag_s1   <= T_NONE;
      r_oor_s1   <= 1'b0;
      r_steal_s1 <= 1'b0;
    end else if (w_aux_slot) begin
      o_rom_row  <= r_aux_row;
      o_rom_col  <= w_aux_col[9:0];
      r_tag_s1   <= w_aux_at_last ? T_AUX_LAST : T_AUX;
      r_oor_s1   <= w_aux_oor;
      r_steal_s1 <= w_steal;
    end else if (i_vid_en) begin
      o_rom_row  <= i_vid_row;
      o_rom_col  <= i_vid_col;
      r_tag_s1   <= T_VID;
      r_oor_s1   <= w_vid_oor;
      r_steal_s1 <= 1'b0;
    end else begin
      r_tag_s1   <= T_NONE;
      r_oor_s1   <= 1'b0;
      r_steal_s1 <= 1'b0;
    end
  end

  // S1: the ROM reads the held address; move the tag into step with i_rom_data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_s2   <= T_NONE;
      r_oor_s2   <= 1'b0;
      r_steal_s2 <= 1'b0;
    end else begin
      r_tag_s2   <= r_tag_s1;
      r_oor_s2   <= r_oor_s1;
      r_steal_s2 <= r_steal_s1;
    end
  end

  // S2: steer ROM data to its requester; out-of-range pixels read as black
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vid_valid  <= 1'b0;
      o_vid_data   <= 12'h000;
      o_aux_valid  <= 1'b0;
      o_aux_data   <= 12'h000;
      o_aux_last   <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      o_vid_stolen <= 1'b0;
`endif
    end else begin
      // A stolen slot keeps the previous video pixel on o_vid_data
      o_vid_valid <= (r_tag_s2 == T_VID) || r_steal_s2;
      if (r_tag_s2 == T_VID) begin
        o_vid_data <= r_oor_s2 ? 12'h000 : i_rom_data;
      end
      o_aux_valid <= (r_tag_s2 == T_AUX) || (r_tag_s2 == T_AUX_LAST);
      o_aux_last  <= (r_tag_s2 == T_AUX_LAST);
      if ((r_tag_s2 == T_AUX) || (r_tag_s2 == T_AUX_LAST)) begin
        o_aux_data <= r_oor_s2 ? 12'h000 : i_rom_data;
      end
`ifdef ARB_STARVE_GUARD_EN
      o_vid_stolen <= r_steal_s2;
`endif
    end
  end

endmodule
